// File: rtl/line_xfer_engine.sv
// -----------------------------------------------------------------------------
// line_xfer_engine
//
// Moves one cache line between a lane-split SRAM and a word-wide memory port,
// staging it through an internal BLOCK_WORDS x W line buffer.
//   op 00 : fill           memory -> buffer -> SRAM
//   op 01 : evict          SRAM -> buffer -> memory
//   op 10 : evict+fill     SRAM -> buffer -> memory, then memory -> buffer -> SRAM
//   op 11 : illegal        one-cycle err pulse, nothing else happens
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start, op           request strobe (only sampled while idle) and operation
//   sram_base           SRAM word address of line word 0
//   evict_addr          memory byte address of the line to write back
//   fill_addr           memory byte address of the line to fetch
//   busy, done, err     status; done and err are one-cycle pulses
//   sram_*              shared SRAM address, per-lane sense/write enables, data
//   mem_*               memory request port; a request is held until mem_ack
//   crit_valid/data     critical-word early delivery (optional feature)
//
// Optional feature macro: LINE_XFER_CRIT_FIRST_EN
//   Defined   : the fetch starts at the word addressed by fill_addr and wraps
//               around the line; that first word is also presented on
//               crit_data with a crit_valid pulse one cycle after its ack.
//   Undefined : the fetch starts at word 0; crit_valid/crit_data are tied to 0.
// -----------------------------------------------------------------------------
module line_xfer_engine #(
   parameter int LANES       = 4,
   parameter int BLOCK_WORDS = 32,
   parameter int SRAM_AW     = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [SRAM_AW-1:0]   sram_base,
   input  logic [31:0]          evict_addr,
   input  logic [31:0]          fill_addr,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic [LANES-1:0]     sram_sense_en,
   output logic [LANES-1:0]     sram_wen,
   output logic [8*LANES-1:0]   sram_din,
   input  logic [8*LANES-1:0]   sram_dout,
   output logic [31:0]          mem_addr,
   output logic [8*LANES-1:0]   mem_din,
   input  logic [8*LANES-1:0]   mem_dout,
   output logic                 mem_ren,
   output logic                 mem_wen,
   input  logic                 mem_ack,
   output logic                 crit_valid,
   output logic [8*LANES-1:0]   crit_data
);

   localparam int W   = 8 * LANES;
   localparam int KW  = $clog2(BLOCK_WORDS);   // word index width
   localparam int LB  = $clog2(LANES);         // byte offset within a word
   localparam int OFF = KW + LB;               // byte offset within a line

   localparam logic [31:0] BASE_MASK = ~((32'd1 << OFF) - 32'd1);
   localparam logic [KW:0] CNT_ONE   = (KW+1)'(1);
   localparam logic [KW:0] CNT_LAST  = (KW+1)'(BLOCK_WORDS - 1);
   localparam logic [KW:0] CNT_FULL  = (KW+1)'(BLOCK_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      SRAM_TO_BUF,
      BUF_TO_MEM,
      MEM_TO_BUF,
      BUF_TO_SRAM,
      DONE
   } state_t;

   state_t               state_reg;
   logic [KW:0]          cnt_reg;            // word / cycle counter within a phase
   logic                 evict_then_fill_reg;
   logic [SRAM_AW-1:0]   sram_base_reg;
   logic [31:0]          evict_base_reg;
   logic [31:0]          fill_base_reg;
   logic [KW-1:0]        start_idx_reg;      // first word fetched from memory

   logic [KW-1:0]        cnt_low;
   logic [KW-1:0]        next_low;
   logic [KW-1:0]        fidx;               // buffer index of the current fetch
   logic [KW-1:0]        fidx_inc;
   logic [KW-1:0]        fill_crit;

   // Line buffer: written from the capture mux below, read through registers
   // in the FSM.
   logic [W-1:0]         line_buf [BLOCK_WORDS];
   logic                 buf_we;
   logic [KW-1:0]        buf_widx;
   logic [W-1:0]         buf_wdata;

   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [KW-1:0] idx);
      logic [31:0] ofs;
      ofs = 32'(idx) << LB;
      return base | ofs;
   endfunction

`ifdef LINE_XFER_CRIT_FIRST_EN
   assign fill_crit = fill_addr[LB +: KW];
`else
   assign fill_crit = '0;
`endif

   assign cnt_low  = cnt_reg[KW-1:0];
   assign next_low = cnt_low + KW'(1);
   assign fidx     = start_idx_reg + cnt_low;
   assign fidx_inc = fidx + KW'(1);

   // SRAM read data arrives one cycle after sense_en, so in SRAM_TO_BUF
   // cycle c (c >= 1) carries word c-1.
   always_comb begin
      buf_we    = 1'b0;
      buf_widx  = fidx;
      buf_wdata = mem_dout;
      if (state_reg == SRAM_TO_BUF && cnt_reg != '0) begin
         buf_we    = 1'b1;
         buf_widx  = cnt_low - KW'(1);
         buf_wdata = sram_dout;
      end else if (state_reg == MEM_TO_BUF && mem_ack) begin
         buf_we    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) begin
         line_buf[buf_widx] <= buf_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg           <= IDLE;
         cnt_reg             <= '0;
         evict_then_fill_reg <= 1'b0;
         sram_base_reg       <= '0;
         evict_base_reg      <= '0;
         fill_base_reg       <= '0;
         start_idx_reg       <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         err                 <= 1'b0;
         sram_addr           <= '0;
         sram_sense_en       <= '0;
         sram_wen            <= '0;
         sram_din            <= '0;
         mem_addr            <= '0;
         mem_din             <= '0;
         mem_ren             <= 1'b0;
         mem_wen             <= 1'b0;
`ifdef LINE_XFER_CRIT_FIRST_EN
         crit_valid          <= 1'b0;
         crit_data           <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
`ifdef LINE_XFER_CRIT_FIRST_EN
         crit_valid <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (op == 2'b11) begin
                     err <= 1'b1;
                  end else begin
                     busy                <= 1'b1;
                     cnt_reg             <= '0;
                     evict_then_fill_reg <= (op == 2'b10);
                     sram_base_reg       <= sram_base;
                     evict_base_reg      <= evict_addr & BASE_MASK;
                     fill_base_reg       <= fill_addr & BASE_MASK;
                     start_idx_reg       <= fill_crit;
                     if (op == 2'b00) begin
                        state_reg <= MEM_TO_BUF;
                        mem_ren   <= 1'b1;
                        mem_addr  <= word_addr(fill_addr & BASE_MASK, fill_crit);
                     end else begin
                        state_reg     <= SRAM_TO_BUF;
                        sram_sense_en <= '1;
                        sram_addr     <= sram_base;
                     end
                  end
               end
            end

            // BLOCK_WORDS read cycles plus one trailing capture cycle.
            SRAM_TO_BUF: begin
               cnt_reg <= cnt_reg + CNT_ONE;
               if (cnt_reg < CNT_LAST) begin
                  sram_addr <= sram_base_reg + SRAM_AW'(next_low);
               end else begin
                  sram_sense_en <= '0;
               end
               if (cnt_reg == CNT_FULL) begin
                  state_reg <= BUF_TO_MEM;
                  cnt_reg   <= '0;
                  mem_wen   <= 1'b1;
                  mem_addr  <= evict_base_reg;
                  mem_din   <= line_buf[0];
               end
            end

            BUF_TO_MEM: begin
               if (mem_ack) begin
                  if (cnt_reg == CNT_LAST) begin
                     mem_wen <= 1'b0;
                     cnt_reg <= '0;
                     if (evict_then_fill_reg) begin
                        state_reg <= MEM_TO_BUF;
                        mem_ren   <= 1'b1;
                        mem_addr  <= word_addr(fill_base_reg, start_idx_reg);
                     end else begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                     end
                  end else begin
                     cnt_reg  <= cnt_reg + CNT_ONE;
                     mem_addr <= word_addr(evict_base_reg, next_low);
                     mem_din  <= line_buf[next_low];
                  end
               end
            end

            MEM_TO_BUF: begin
               if (mem_ack) begin
`ifdef LINE_XFER_CRIT_FIRST_EN
                  if (cnt_reg == '0) begin
                     crit_valid <= 1'b1;
                     crit_data  <= mem_dout;
                  end
`endif
                  if (cnt_reg == CNT_LAST) begin
                     state_reg <= BUF_TO_SRAM;
                     mem_ren   <= 1'b0;
                     cnt_reg   <= '0;
                     sram_wen  <= '1;
                     sram_addr <= sram_base_reg;
                     // Word 0 may be the one landing in the buffer right now
                     // (wrapped fetch order), so forward it directly.
                     sram_din  <= (fidx == '0) ? mem_dout : line_buf[0];
                  end else begin
                     cnt_reg  <= cnt_reg + CNT_ONE;
                     mem_addr <= word_addr(fill_base_reg, fidx_inc);
                  end
               end
            end

            BUF_TO_SRAM: begin
               if (cnt_reg == CNT_LAST) begin
                  sram_wen  <= '0;
                  cnt_reg   <= '0;
                  state_reg <= DONE;
                  done      <= 1'b1;
               end else begin
                  cnt_reg   <= cnt_reg + CNT_ONE;
                  sram_addr <= sram_base_reg + SRAM_AW'(next_low);
                  sram_din  <= line_buf[next_low];
               end
            end

            DONE: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifndef LINE_XFER_CRIT_FIRST_EN
   assign crit_valid = 1'b0;
   assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_line_xfer_engine.sv
// Directed bench for line_xfer_engine at default parameters.
// A behavioural SRAM (1-cycle read latency) and a memory responder with a
// programmable ack spacing surround the DUT; a negedge monitor logs every
// acknowledged memory beat and counts protocol events.
module tb_line_xfer_engine;

   localparam int LANES       = 4;
   localparam int BLOCK_WORDS = 32;
   localparam int SRAM_AW     = 10;
   localparam int W           = 8 * LANES;

`ifdef LINE_XFER_CRIT_FIRST_EN
   localparam logic [31:0] A_FIRST = 32'hACE12004;
   localparam logic [31:0] A_LAST  = 32'hACE12000;
   localparam int          A_CRIT  = 1;
`else
   localparam logic [31:0] A_FIRST = 32'hACE12000;
   localparam logic [31:0] A_LAST  = 32'hACE1207C;
   localparam int          A_CRIT  = 0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [1:0]         op = 2'b00;
   logic [SRAM_AW-1:0] sram_base = '0;
   logic [31:0]        evict_addr = '0;
   logic [31:0]        fill_addr = '0;
   logic               busy, done, err;
   logic [SRAM_AW-1:0] sram_addr;
   logic [LANES-1:0]   sram_sense_en, sram_wen;
   logic [W-1:0]       sram_din;
   logic [W-1:0]       sram_dout = '0;
   logic [31:0]        mem_addr;
   logic [W-1:0]       mem_din;
   logic [W-1:0]       mem_dout = '0;
   logic               mem_ren, mem_wen;
   logic               mem_ack = 1'b0;
   logic               crit_valid;
   logic [W-1:0]       crit_data;

   always #5 clk = ~clk;

   line_xfer_engine #(
      .LANES(LANES), .BLOCK_WORDS(BLOCK_WORDS), .SRAM_AW(SRAM_AW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .sram_base(sram_base),
      .evict_addr(evict_addr), .fill_addr(fill_addr), .busy(busy), .done(done),
      .err(err), .sram_addr(sram_addr), .sram_sense_en(sram_sense_en),
      .sram_wen(sram_wen), .sram_din(sram_din), .sram_dout(sram_dout),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_ack(mem_ack),
      .crit_valid(crit_valid), .crit_data(crit_data)
   );

   // ---------------- SRAM model ----------------
   logic [W-1:0] sram_mem [1 << SRAM_AW];

   always @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (sram_wen[l]) sram_mem[sram_addr][8*l +: 8] = sram_din[8*l +: 8];
      end
      if (|sram_sense_en) sram_dout <= sram_mem[sram_addr];
   end

   // ---------------- memory responder + monitor ----------------
   int          ack_period = 1;
   int          ack_div = 0;
   logic        stray_ack = 1'b0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] rd_addr_q[$];
   bit          order_q[$];
   int          done_cnt, err_cnt, crit_cnt, both_mem_cnt, both_sram_cnt, stab_cnt;
   logic [W-1:0] crit_last;
   logic        prev_req = 1'b0, prev_ack = 1'b0, prev_wen = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [W-1:0] prev_din = '0;

   always @(negedge clk) begin
      if (mem_ren || mem_wen) begin
         if (ack_div >= ack_period - 1) begin
            mem_ack = 1'b1;
            ack_div = 0;
         end else begin
            mem_ack = 1'b0;
            ack_div++;
         end
      end else begin
         mem_ack = stray_ack;
         ack_div = 0;
      end
      mem_dout = {4{mem_addr[9:2]}};
      if (mem_ack && mem_wen) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_din);
         order_q.push_back(1'b1);
      end
      if (mem_ack && mem_ren) begin
         rd_addr_q.push_back(mem_addr);
         order_q.push_back(1'b0);
      end
      if (mem_ren && mem_wen) both_mem_cnt++;
      if ((|sram_sense_en) && (|sram_wen)) both_sram_cnt++;
      if ((mem_ren || mem_wen) && prev_req && !prev_ack &&
          (mem_addr !== prev_addr || mem_din !== prev_din || mem_wen !== prev_wen))
         stab_cnt++;
      prev_req  = mem_ren || mem_wen;
      prev_ack  = mem_ack;
      prev_wen  = mem_wen;
      prev_addr = mem_addr;
      prev_din  = mem_din;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (crit_valid) begin
         crit_cnt++;
         crit_last = crit_data;
      end
   end

   // ---------------- checking helpers ----------------
   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
      order_q.delete();
      done_cnt = 0; err_cnt = 0; crit_cnt = 0;
      both_mem_cnt = 0; both_sram_cnt = 0; stab_cnt = 0;
      crit_last = '0;
   endtask

   task automatic preload(input logic [31:0] pattern);
      for (int a = 0; a < (1 << SRAM_AW); a++) sram_mem[a] = pattern;
   endtask

   // Issues one request, then scrambles the inputs and retries start while
   // busy so that latching and busy-ignore are exercised on every transfer.
   task automatic run_op(input logic [1:0] o, input logic [SRAM_AW-1:0] sb,
                         input logic [31:0] ea, input logic [31:0] fa,
                         input int budget, output bit timed_out);
      clear_logs();
      @(negedge clk);
      op = o; sram_base = sb; evict_addr = ea; fill_addr = fa; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op = ~o; sram_base = ~sb; evict_addr = ~ea; fill_addr = ~fa;
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         start = (i == 5);
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
      end
      start = 1'b0;
      repeat (2) @(negedge clk);
      $display("xfer op=%0d reads=%0d writes=%0d done_pulses=%0d err_pulses=%0d",
               o, rd_addr_q.size(), wr_addr_q.size(), done_cnt, err_cnt);
   endtask

   int first_rd;
   bit to;

   initial begin
      clear_logs();
      preload(32'hFFFF_FFFF);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);

      // ---- reset state ----
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mem_req", {mem_ren, mem_wen}, 0);
      check("rst_sram_en", {sram_sense_en, sram_wen}, 0);
      check("rst_addrs", {sram_addr, mem_addr}, 0);
      check("rst_crit", crit_valid, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // ---- fill: op 00, fill 0xACE12004, ack every cycle ----
      ack_period = 1;
      run_op(2'b00, 10'h100, 32'h0, 32'hACE12004, 400, to);
      check("fill_timeout", to, 0);
      check("fill_reads", rd_addr_q.size(), 32);
      check("fill_writes", wr_addr_q.size(), 0);
      check("fill_first_addr", rd_addr_q[0], A_FIRST);
      check("fill_last_addr", rd_addr_q[31], A_LAST);
      check("fill_sram_w0", sram_mem[10'h100], 32'h00000000);
      check("fill_sram_w1", sram_mem[10'h101], 32'h01010101);
      check("fill_sram_w31", sram_mem[10'h11F], 32'h1F1F1F1F);
      check("fill_sram_past", sram_mem[10'h120], 32'hFFFFFFFF);
      check("fill_done_cnt", done_cnt, 1);
      check("fill_no_err", err_cnt, 0);
      check("fill_crit_cnt", crit_cnt, A_CRIT);
      check("fill_busy_end", busy, 0);

      // ---- evict: op 01, base wraps 0x3FE->0x001, ack every 3rd cycle ----
      preload(32'hFFFF_FFFF);
      for (int k = 0; k < BLOCK_WORDS; k++)
         sram_mem[SRAM_AW'(10'h3FE + k)] = 32'h5A5A0000 + k;
      sram_mem[10'h001] = 32'hDEADBEEF;
      ack_period = 3;
      run_op(2'b01, 10'h3FE, 32'hBEEF2044, 32'h0, 600, to);
      check("evict_timeout", to, 0);
      check("evict_writes", wr_addr_q.size(), 32);
      check("evict_reads", rd_addr_q.size(), 0);
      check("evict_w0_addr", wr_addr_q[0], 32'hBEEF2000);
      check("evict_w0_data", wr_data_q[0], 32'h5A5A0000);
      check("evict_wrap_data", wr_data_q[2], 32'h5A5A0002);
      check("evict_w3_addr", wr_addr_q[3], 32'hBEEF200C);
      check("evict_w3_data", wr_data_q[3], 32'hDEADBEEF);
      check("evict_w31_addr", wr_addr_q[31], 32'hBEEF207C);
      check("evict_w31_data", wr_data_q[31], 32'h5A5A001F);
      check("evict_stable", stab_cnt, 0);
      check("evict_done_cnt", done_cnt, 1);

      // ---- evict then fill: op 10 ----
      preload(32'hFFFF_FFFF);
      for (int k = 0; k < BLOCK_WORDS; k++) sram_mem[10'h200 + k] = 32'h11000000 + k;
      ack_period = 1;
      run_op(2'b10, 10'h200, 32'hBEEF2000, 32'hACE12000, 600, to);
      first_rd = -1;
      for (int i = 0; i < order_q.size(); i++) begin
         if (!order_q[i] && first_rd < 0) first_rd = i;
      end
      check("ef_timeout", to, 0);
      check("ef_writes", wr_addr_q.size(), 32);
      check("ef_reads", rd_addr_q.size(), 32);
      check("ef_writes_first", first_rd, 32);
      check("ef_w0_addr", wr_addr_q[0], 32'hBEEF2000);
      check("ef_w5_data", wr_data_q[5], 32'h11000005);
      check("ef_r0_addr", rd_addr_q[0], 32'hACE12000);
      check("ef_sram_w5", sram_mem[10'h205], 32'h05050505);
      check("ef_done_cnt", done_cnt, 1);
      check("ef_exclusive", both_mem_cnt + both_sram_cnt, 0);

`ifdef LINE_XFER_CRIT_FIRST_EN
      // ---- critical word first: fill 0xACE1207C ----
      preload(32'hFFFF_FFFF);
      run_op(2'b00, 10'h100, 32'h0, 32'hACE1207C, 400, to);
      check("crit_timeout", to, 0);
      check("crit_first_addr", rd_addr_q[0], 32'hACE1207C);
      check("crit_second_addr", rd_addr_q[1], 32'hACE12000);
      check("crit_cnt", crit_cnt, 1);
      check("crit_data", crit_last, 32'h1F1F1F1F);
      check("crit_sram_w0", sram_mem[10'h100], 32'h00000000);
      check("crit_sram_w31", sram_mem[10'h11F], 32'h1F1F1F1F);
`endif

      // ---- illegal op and stray ack ----
      clear_logs();
      @(negedge clk);
      op = 2'b11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ill_err_pulse", err, 1);
      check("ill_busy", busy, 0);
      @(negedge clk);
      check("ill_err_clear", err, 0);
      stray_ack = 1'b1;
      repeat (3) @(negedge clk);
      stray_ack = 1'b0;
      check("ill_idle_outputs", {busy, mem_ren, mem_wen, sram_wen, sram_sense_en}, 0);
      check("ill_err_cnt", err_cnt, 1);
      check("ill_done_cnt", done_cnt, 0);
      $display("xfer op=3 err_pulses=%0d done_pulses=%0d", err_cnt, done_cnt);

      // ---- reset in the middle of BUF_TO_MEM ----
      clear_logs();
      ack_period = 3;
      @(negedge clk);
      op = 2'b01; sram_base = 10'h000; evict_addr = 32'h12340000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (wr_addr_q.size() >= 2) begin
            to = 1'b0;
            break;
         end
      end
      check("mrst_reach_wr", to, 0);
      check("mrst_wen_before", mem_wen, 1);
      #2 rst = 1'b0;
      #1;
      check("mrst_wen_now", mem_wen, 0);
      check("mrst_busy_now", busy, 0);
      check("mrst_addr_now", mem_addr, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("mrst_no_done", done_cnt, 0);
      check("mrst_idle", {busy, mem_wen, mem_ren}, 0);
      $display("xfer op=1 aborted_by_reset writes=%0d done_pulses=%0d", wr_addr_q.size(), done_cnt);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
